dcr_dispatch: RTL

DCR_DISPATCH -- requirements
Module: dcr_dispatch

---
 rtl/dcr_dispatch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dcr_dispatch.sv
// Kernel dispatcher: DCR register file plus a block scheduler that hands
// thread blocks to free compute cores and tracks their completion.
module dcr_dispatch #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 16,
  parameter int NUM_CORES = 2,
  parameter int TPB       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             dcr_address,
  input  logic [DATA_W-1:0]             dcr_data_in,
  input  logic                          dcr_write_enable,
  output logic [DATA_W-1:0]             dcr_data_out,
  output logic                          dcr_write_err,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES*DATA_W-1:0]   core_block_id,
  output logic [NUM_CORES*DATA_W-1:0]   core_thread_count,
  input  logic [NUM_CORES-1:0]          core_done
);

  localparam int CW  = DATA_W + 1;
  localparam int TSH = $clog2(TPB);

  // IDLE: no kernel yet | RUN: dispatching/awaiting blocks | DONE: kernel finished, sticky
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        state, state_nxt;
  logic [DATA_W-1:0]             regs [NUM_REGS];
  logic                          start_q, start_blk;
  logic [CW-1:0]                 total_blocks, next_block, blocks_done;

  logic                          addr_ok, wr_ok, start_edge, launch, dispatch;
  logic [DATA_W-1:0]             rd_data, last_rem, disp_count;
  logic [CW-1:0]                 total_calc, done_cnt;
  logic [NUM_CORES-1:0]          acc, pick, start_nxt;
  logic [NUM_CORES*DATA_W-1:0]   id_nxt, cnt_nxt;

  assign busy         = (state == S_RUN);
  assign done         = (state == S_DONE);
  assign dcr_data_out = rd_data;

  // start_blk suppresses a launch from a start level that was already high at reset release
  assign start_edge = start & ~start_q & ~start_blk;
  assign launch     = start_edge & (state != S_RUN);
  assign wr_ok      = dcr_write_enable & addr_ok & (state != S_RUN);
  assign total_calc = ({1'b0, regs[0]} + CW'(TPB - 1)) >> TSH;
  assign last_rem   = regs[0] & DATA_W'(TPB - 1);

  always_comb begin
    addr_ok = 1'b0;
    rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (dcr_address == ADDR_W'(r)) begin
        addr_ok = 1'b1;
        rd_data = regs[r];
      end
    end
  end

  always_comb begin
    acc      = core_start & core_done;
    done_cnt = '0;
    pick     = '0;
    for (int i = 0; i < NUM_CORES; i++) done_cnt = done_cnt + CW'(acc[i]);
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!core_start[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    dispatch   = (state == S_RUN) && (|pick) && (next_block < total_blocks);
    disp_count = ((next_block == total_blocks - CW'(1)) && (last_rem != '0)) ? last_rem : DATA_W'(TPB);
    start_nxt  = core_start & ~acc;
    id_nxt     = core_block_id;
    cnt_nxt    = core_thread_count;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (dispatch && pick[i]) begin
        start_nxt[i]                  = 1'b1;
        id_nxt[i*DATA_W +: DATA_W]    = next_block[DATA_W-1:0];
        cnt_nxt[i*DATA_W +: DATA_W]   = disp_count;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (launch) state_nxt = S_RUN;
      S_RUN:          if (blocks_done == total_blocks) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      start_q           <= 1'b0;
      start_blk         <= 1'b1;
      dcr_write_err     <= 1'b0;
      total_blocks      <= '0;
      next_block        <= '0;
      blocks_done       <= '0;
      core_start        <= '0;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else begin
      start_q       <= start;
      start_blk     <= start_blk & start;
      dcr_write_err <= dcr_write_enable & ~wr_ok;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_ok && dcr_address == ADDR_W'(r)) regs[r] <= dcr_data_in;
      end
      if (launch) begin
        total_blocks <= total_calc;
        next_block   <= '0;
        blocks_done  <= '0;
        core_start   <= '0;
      end else if (state == S_RUN) begin
        blocks_done       <= blocks_done + done_cnt;
        core_start        <= start_nxt;
        core_block_id     <= id_nxt;
        core_thread_count <= cnt_nxt;
        if (dispatch) next_block <= next_block + CW'(1);
      end
    end
  end

endmodule
